// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: a single word-addressed RAM shared by an instruction-fetch
// port and a data port. Data has priority, and a starve counter bounds how long a
// pending fetch can wait. Every access takes 2+WAIT_STATES cycles: IDLE, WAIT, DONE.
// Stores are byte-enabled and return the word as it was before the write.
// Optional feature: define MEM_ARB_STATS_EN to build a saturating fetch-stall
// counter on stat_if_stall. Without it, stat_if_stall is tied to zero.
module unified_mem_arbiter #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        busy,
  output logic [31:0] stat_if_stall
);
  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [2:0]  WAIT_LAST  = 3'(WAIT_STATES - 1);
  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [2:0]    wait_cnt;
  logic [7:0]    starve_cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  // Copies of the granted request, captured when the grant is made
  logic          gnt_d_p0;
  logic          we_p0;
  logic          legal_p0;
  logic [3:0]    be_p0;
  logic [AW-1:0] idx_p0;
  logic [31:0]   wdata_p0;

  logic          fetch_forced;
  logic          grant_d;
  logic          grant_any;
  logic [31:0]   sel_addr;
  logic [31:0]   rd_word;

  // Word aligned and inside the RAM; upper bits must be zero so nothing aliases
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
  endfunction

  // Grant decision: data wins unless the fetch has waited out its starve budget
  always_comb begin
    fetch_forced = if_req && (starve_cnt == STARVE_MAX);
    grant_d      = d_req && !fetch_forced;
    grant_any    = d_req || if_req;
    sel_addr     = grant_d ? d_addr : if_addr;
  end

  assign rd_word = mem[idx_p0];
  assign busy    = (state != IDLE);

  // Access sequencer: grant in IDLE, count wait states, complete in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      gnt_d_p0   <= 1'b0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      d_err      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            gnt_d_p0 <= grant_d;
            wait_cnt <= '0;
            if (!grant_d) begin
              starve_cnt <= '0;
            end else if (if_req) begin
              starve_cnt <= starve_cnt + 8'd1;
            end
            state <= (WAIT_STATES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (gnt_d_p0) begin
            d_ready <= 1'b1;
            d_err   <= !legal_p0;
            d_rdata <= legal_p0 ? rd_word : '0;
          end else begin
            if_ready <= 1'b1;
            if_rdata <= legal_p0 ? rd_word : NOP_INSN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the winning request; later request changes are ignored
  always_ff @(posedge clk) begin
    if ((state == IDLE) && grant_any) begin
      we_p0    <= grant_d && d_we;
      be_p0    <= d_be;
      legal_p0 <= addr_legal(sel_addr);
      idx_p0   <= sel_addr[AW+1:2];
      wdata_p0 <= d_wdata;
    end
  end

  // Byte-enabled store on the DONE edge; the read above sees the old word
  always_ff @(posedge clk) begin
    if ((state == DONE) && we_p0 && legal_p0) begin
      for (int b = 0; b < 4; b++) begin
        if (be_p0[b]) begin
          mem[idx_p0][8*b +: 8] <= wdata_p0[8*b +: 8];
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stall_cnt;

  // Cycles a fetch is requested but not yet completed, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (if_req && !if_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_if_stall = stall_cnt;
`else
  assign stat_if_stall = '0;
`endif

endmodule
